// File: rtl/hd_link_pkg.sv
// Shared constants, state encodings and counter sizing for the
// half-duplex link controller.
package hd_link_pkg;

   localparam int DATA_W_DEF   = 8;
   localparam int TURN_CYC_DEF = 2;

   typedef logic [2:0] state_t;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_DRIVE    = 3'd1;
   localparam logic [2:0] ST_TURN_OUT = 3'd2;
   localparam logic [2:0] ST_SAMPLE   = 3'd3;
   localparam logic [2:0] ST_RESP     = 3'd4;

   function automatic int cnt_width(input int dw, input int tc);
      int m;
      m = (dw > tc) ? dw : tc;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/hd_shift_unit.sv
// Loadable TX serialiser with a registered line bit, plus the RX
// capture shifter. Bit order is selected by LSB_FIRST.
module hd_shift_unit #(
   parameter int DATA_W    = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic              clr_i,
   input  logic              cap_i,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic              rx_bit_i,
   output logic              tx_bit_o,
   output logic [DATA_W-1:0] rx_data_o
);

   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic              out_q, out_d;

   always_comb begin
      tx_d  = tx_q;
      out_d = out_q;
      rx_d  = rx_q;
      // out_q is the bit on the line; tx_q holds the bits still to send
      if (load_i) begin
         if (LSB_FIRST) begin
            out_d = tx_data_i[0];
            tx_d  = tx_data_i >> 1;
         end else begin
            out_d = tx_data_i[DATA_W-1];
            tx_d  = tx_data_i << 1;
         end
      end else if (shift_i) begin
         if (LSB_FIRST) begin
            out_d = tx_q[0];
            tx_d  = tx_q >> 1;
         end else begin
            out_d = tx_q[DATA_W-1];
            tx_d  = tx_q << 1;
         end
      end else if (clr_i) begin
         out_d = 1'b0;
      end
      if (cap_i) begin
         if (LSB_FIRST) begin
            rx_d = {rx_bit_i, rx_q[DATA_W-1:1]};
         end else begin
            rx_d = {rx_q[DATA_W-2:0], rx_bit_i};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_q  <= '0;
         rx_q  <= '0;
         out_q <= 1'b0;
      end else begin
         tx_q  <= tx_d;
         rx_q  <= rx_d;
         out_q <= out_d;
      end
   end

   assign tx_bit_o  = out_q;
   assign rx_data_o = rx_q;

endmodule

// File: rtl/half_duplex_link_ctrl.sv
// Half-duplex request/reply sequencer: sends one word, releases the
// line for a guard period, captures the reply and hands it back.
module half_duplex_link_ctrl
   import hd_link_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int TURN_CYC  = TURN_CYC_DEF,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy,
   output logic              direction,
   output logic              data_out,
   input  logic              data_in
);

   localparam int CW = cnt_width(DATA_W, TURN_CYC);
   localparam logic [CW-1:0] DW_LD = CW'(DATA_W - 1);
   localparam logic [CW-1:0] TC_LD = CW'(TURN_CYC - 1);
   localparam logic [CW-1:0] ONE   = CW'(1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dir_q, dir_d;
   logic          hs_q, hs_d;
   logic          rv_q, rv_d;
   logic          ld, sh, clr, cap;
   logic          cnt_zero, req_fire, rsp_fire;

   assign cnt_zero  = (cnt_q == '0);
   assign req_ready = (state_q == ST_IDLE);
   assign req_fire  = req_valid & req_ready;
   assign rsp_fire  = rv_q & rsp_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      hs_d    = hs_q;
      rv_d    = rv_q;
      ld      = 1'b0;
      sh      = 1'b0;
      clr     = 1'b0;
      cap     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_fire) begin
               state_d = ST_DRIVE;
               cnt_d   = DW_LD;
               dir_d   = 1'b1;
               ld      = 1'b1;
            end
         end
         ST_DRIVE: begin
            if (cnt_zero) begin
               state_d = ST_TURN_OUT;
               cnt_d   = TC_LD;
               dir_d   = 1'b0;
               clr     = 1'b1;
            end else begin
               cnt_d = cnt_q - ONE;
               sh    = 1'b1;
            end
         end
         ST_TURN_OUT: begin
            if (cnt_zero) begin
               state_d = ST_SAMPLE;
               cnt_d   = DW_LD;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         ST_SAMPLE: begin
            cap = 1'b1;
            if (cnt_zero) begin
               state_d = ST_RESP;
               cnt_d   = TC_LD;
               rv_d    = 1'b1;
               hs_d    = 1'b0;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         ST_RESP: begin
            // reply handshake and return guard complete independently
            if (!cnt_zero) begin
               cnt_d = cnt_q - ONE;
            end
            if (rsp_fire) begin
               rv_d = 1'b0;
               hs_d = 1'b1;
            end
            if ((rsp_fire | hs_q) && cnt_zero) begin
               state_d = ST_IDLE;
               hs_d    = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            dir_d   = 1'b0;
            rv_d    = 1'b0;
            hs_d    = 1'b0;
            clr     = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         hs_q    <= 1'b0;
         rv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         hs_q    <= hs_d;
         rv_q    <= rv_d;
      end
   end

   hd_shift_unit #(
      .DATA_W    (DATA_W),
      .LSB_FIRST (LSB_FIRST)
   ) u_shift (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (ld),
      .shift_i   (sh),
      .clr_i     (clr),
      .cap_i     (cap),
      .tx_data_i (req_data),
      .rx_bit_i  (data_in),
      .tx_bit_o  (data_out),
      .rx_data_o (rsp_data)
   );

   assign direction = dir_q;
   assign rsp_valid = rv_q;
   assign busy      = (state_q != ST_IDLE);

endmodule
